// File: rtl/fp32_ctrl_pkg.sv
// Shared types and defaults for the bit-serial FP32 adder sequencer.
package fp32_ctrl_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_ADD_LAT = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_COMPUTE,
    ST_CAPTURE,
    ST_SHIFT_OUT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/fp32_sout_shift.sv
// Parallel-load, left-shift result register that presents its MSB under a
// valid/ready handshake; valid drops after the last bit is taken.
module fp32_sout_shift #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  input  logic             last_i,
  input  logic             clear_i,
  output logic             sout_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] data_q;
  logic             valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (clear_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      valid_q <= 1'b1;
    end else if (valid_q && ready_i) begin
      data_q <= {data_q[WIDTH-2:0], 1'b0};
      if (last_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign sout_o  = data_q[WIDTH-1];
  assign valid_o = valid_q;

endmodule

// File: rtl/fp32_serial_ctrl.sv
// Sequencer for the bit-serial FP32 adder: loads A then B serially, waits the
// adder latency, then streams the sum out. FP32_SER_CTRL_ABORT_EN adds 'abort'.
module fp32_serial_ctrl
  import fp32_ctrl_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int ADD_LAT = DEF_ADD_LAT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sin,
  input  logic             sin_valid,
`ifdef FP32_SER_CTRL_ABORT_EN
  input  logic             abort,
`endif
  output logic             lda,
  output logic             ldb,
  output logic             inp_ab,
  input  logic [WIDTH-1:0] sum,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int LAT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [LAT_W-1:0] LAST_LAT = LAT_W'(ADD_LAT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   bitCnt_q, bitCnt_d;
  logic [LAT_W-1:0]   latCnt_q, latCnt_d;
  logic               shLoad, shLast, shFire, abortHit;

`ifdef FP32_SER_CTRL_ABORT_EN
  assign abortHit = abort && (state_q != ST_IDLE);
`else
  assign abortHit = 1'b0;
`endif

  assign shFire = sout_valid && sout_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      bitCnt_q <= '0;
      latCnt_q <= '0;
    end else begin
      state_q  <= state_d;
      bitCnt_q <= bitCnt_d;
      latCnt_q <= latCnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bitCnt_d = bitCnt_q;
    latCnt_d = latCnt_q;
    shLoad   = 1'b0;
    shLast   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_LOAD_A;
          bitCnt_d = '0;
        end
      end
      ST_LOAD_A: begin
        if (sin_valid) begin
          if (bitCnt_q == LAST_BIT) begin
            state_d  = ST_LOAD_B;
            bitCnt_d = '0;
          end else begin
            bitCnt_d = bitCnt_q + 1'b1;
          end
        end
      end
      ST_LOAD_B: begin
        if (sin_valid) begin
          if (bitCnt_q == LAST_BIT) begin
            state_d  = ST_COMPUTE;
            latCnt_d = '0;
          end else begin
            bitCnt_d = bitCnt_q + 1'b1;
          end
        end
      end
      ST_COMPUTE: begin
        if (latCnt_q == LAST_LAT) begin
          state_d = ST_CAPTURE;
        end else begin
          latCnt_d = latCnt_q + 1'b1;
        end
      end
      ST_CAPTURE: begin
        shLoad   = 1'b1;
        state_d  = ST_SHIFT_OUT;
        bitCnt_d = '0;
      end
      ST_SHIFT_OUT: begin
        if (shFire) begin
          if (bitCnt_q == LAST_BIT) begin
            shLast  = 1'b1;
            state_d = ST_DONE;
          end else begin
            bitCnt_d = bitCnt_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides whatever the current state decided.
    if (abortHit) begin
      state_d  = ST_IDLE;
      bitCnt_d = '0;
      latCnt_d = '0;
      shLoad   = 1'b0;
    end
  end

  assign lda    = (state_q == ST_LOAD_A) && sin_valid;
  assign ldb    = (state_q == ST_LOAD_B) && sin_valid;
  assign inp_ab = sin;
  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);

  fp32_sout_shift #(.WIDTH(WIDTH)) u_sout_shift (
    .clk     (clk),
    .reset   (reset),
    .load_i  (shLoad),
    .data_i  (sum),
    .ready_i (sout_ready),
    .last_i  (shLast),
    .clear_i (abortHit),
    .sout_o  (sout),
    .valid_o (sout_valid)
  );

endmodule
